// File: rtl/fetch_queue.sv
// fetch_queue: RV32 instruction-fetch stage.
//
// It generates PCs and issues single-beat requests on a variable-latency
// instruction bus, with at most one request outstanding. Responses are
// stored as {PC, instruction} pairs in a DEPTH-entry queue. The queue head
// is presented to decode from registered queue state. A redirect flushes the
// queue and restarts fetch at a new PC. Any response still in flight for the
// old stream is absorbed without being queued.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target sets a sticky oMisaligned flag
//               and halts fetch until an aligned redirect or reset.
//   undefined : the redirect target is forced to word alignment, and
//               oMisaligned is tied to 0.
//
// Ports:
//   iCLK, iRST            clock, asynchronous active-high reset
//   iInitialPC            fetch PC loaded while iRST is high
//   oIReq, oIAddr         bus request pulse and fetch address
//   iIValid, iIData       bus response strobe and instruction word
//   oValid, oInstr, oPC   queue head (valid when occupancy is non-zero)
//   iReady                decode accepts the head
//   iRedirect, iRedirectPC  flush and restart fetch at iRedirectPC
//   oCount                queue occupancy
//   oMisaligned           sticky misaligned-target flag
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [XLEN-1:0]          iInitialPC,
    output logic                     oIReq,
    output logic [XLEN-1:0]          oIAddr,
    input  logic                     iIValid,
    input  logic [31:0]              iIData,
    output logic                     oValid,
    output logic [31:0]              oInstr,
    output logic [XLEN-1:0]          oPC,
    input  logic                     iReady,
    input  logic                     iRedirect,
    input  logic [XLEN-1:0]          iRedirectPC,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oMisaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
`ifdef FETCH_ALIGN_CHECK_EN
        , S_HALT
`endif
    } state_t;

    state_t             state;
    logic [XLEN-1:0]    fetch_pc;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [XLEN-1:0]    pc_mem    [DEPTH];
    logic [31:0]        instr_mem [DEPTH];

    logic               issue;
    logic               push;
    logic               pop;
    logic               in_flight;
    logic               stale_left;
    logic [XLEN-1:0]    redirect_pc;

    // Redirect outranks push, pop and issue, so each of them is masked by it.
    // The request is also held low while reset is asserted.
    assign issue = (state == S_IDLE) && (count < CW'(DEPTH)) && !iRedirect && !iRST;
    assign push  = (state == S_WAIT) && iIValid && !iRedirect;
    assign pop   = (count != '0) && iReady && !iRedirect;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    // Set when a misaligned redirect leaves a request unanswered. HALT must
    // then swallow that response, just as DROP would.
    logic halt_owes;

    assign redirect_pc = iRedirectPC;
    assign in_flight   = (state == S_WAIT) || (state == S_DROP) ||
                         ((state == S_HALT) && halt_owes);
    assign oMisaligned = misaligned;
`else
    assign redirect_pc = iRedirectPC & ~XLEN'(3);
    assign in_flight   = (state == S_WAIT) || (state == S_DROP);
    assign oMisaligned = 1'b0;
`endif

    // A response that is still owed after this cycle belongs to the old
    // stream and must be absorbed in DROP.
    assign stale_left = in_flight && !iIValid;

    assign oIReq  = issue;
    assign oIAddr = fetch_pc;
    assign oValid = (count != '0);
    assign oCount = count;
    // The storage is not reset, so the head is forced to zero while the
    // queue is empty.
    assign oPC    = oValid ? pc_mem[rd_ptr]    : '0;
    assign oInstr = oValid ? instr_mem[rd_ptr] : '0;

    // NOTE: the queue storage has no reset. Occupancy and pointers decide
    // what is valid, so clearing the entries would only add reset fan-out.
    always_ff @(posedge iCLK) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= iIData;
        end
    end

    // NOTE: all state uses non-blocking assignments. Every branch then reads
    // the values from before this edge, whatever order it is written in.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= S_IDLE;
            fetch_pc <= iInitialPC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned <= 1'b0;
            halt_owes  <= 1'b0;
`endif
        end else if (iRedirect) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            if (iRedirectPC[1:0] != 2'b00) begin
                misaligned <= 1'b1;
                halt_owes  <= stale_left;
                state      <= S_HALT;
            end else begin
                misaligned <= 1'b0;
                halt_owes  <= 1'b0;
                state      <= stale_left ? S_DROP : S_IDLE;
            end
`else
            state <= stale_left ? S_DROP : S_IDLE;
`endif
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            unique case (state)
                S_IDLE: if (issue) state <= S_WAIT;
                S_WAIT: begin
                    // The queue had room when this request was issued, and
                    // only pops can have happened since, so push never overflows.
                    if (iIValid) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                        state    <= S_IDLE;
                    end
                end
                S_DROP: if (iIValid) state <= S_IDLE;
`ifdef FETCH_ALIGN_CHECK_EN
                S_HALT: if (iIValid) halt_owes <= 1'b0;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (XLEN=32, DEPTH=4).
//
// The bus model answers each request after bus_lat cycles. The returned word
// is the address XOR a fixed key, so the PC and the instruction differ. The
// address monitor checks each request against the expected fetch addresses.
// The head monitor checks each popped {PC, instruction} pair against the
// expected heads. Directed sequences load both queues and check occupancy
// and request timing at fixed cycles.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] initial_pc;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_data;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic        misaligned;

    int n_cmp = 0;
    int n_bad = 0;
    int bus_lat = 1;

    logic [31:0] exp_addrs[$];
    logic [63:0] exp_heads[$];

    fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iInitialPC  (initial_pc),
        .oIReq       (i_req),
        .oIAddr      (i_addr),
        .iIValid     (i_valid),
        .iIData      (i_data),
        .oValid      (valid),
        .oInstr      (instr),
        .oPC         (pc),
        .iReady      (ready),
        .iRedirect   (redirect),
        .iRedirectPC (redirect_pc),
        .oCount      (count),
        .oMisaligned (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_head(input logic [31:0] a);
        exp_heads.push_back({a, a ^ KEY});
    endtask

    // Bus model plus address monitor. A request is recorded away from the
    // edge, and its response is driven just after a later rising edge.
    initial begin : bus_model
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend    = 1'b0;
        cnt     = 0;
        paddr   = '0;
        i_valid = 1'b0;
        i_data  = '0;
        forever begin
            @(negedge clk);
            if (i_req) begin
                if (exp_addrs.size() > 0) check("req_addr", i_addr, exp_addrs.pop_front());
                pend  = 1'b1;
                paddr = i_addr;
                cnt   = bus_lat;
            end
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    i_valid = 1'b1;
                    i_data  = paddr ^ KEY;
                    pend    = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Head monitor: compare every accepted head with the next expected pair.
    initial begin : head_monitor
        forever begin
            @(negedge clk);
            if (!rst && valid && ready) begin
                if (exp_heads.size() > 0) begin
                    check("head", {pc, instr}, exp_heads.pop_front());
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL head_unexpected: got pc=%h instr=%h, expected none (t=%0t)", pc, instr, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, required finish by 100000");
        $fatal(1);
    end

    // Hold reset for several cycles and check the reset values. Deassert it
    // so that the caller resumes at cycle 0 of the new run.
    task automatic do_reset(input logic [31:0] start_pc, input int lat);
        rst         = 1'b1;
        initial_pc  = start_pc;
        redirect    = 1'b0;
        redirect_pc = '0;
        ready       = 1'b0;
        bus_lat     = lat;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_ireq",  i_req, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_mis",   misaligned, 0);
        check("rst_head",  {pc, instr}, 0);
        check("rst_addr",  i_addr, start_pc);
        cyc();
        rst = 1'b0;
    endtask

    task automatic end_scn();
        check("addr_left", exp_addrs.size(), 0);
        check("head_left", exp_heads.size(), 0);
        exp_addrs.delete();
        exp_heads.delete();
    endtask

    initial begin : stimulus
        rst         = 1'b1;
        initial_pc  = '0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Sequential fetch, first-word latency, then backpressure.
        do_reset(32'h0040_0000, 1);
        ready = 1'b1;
        for (int i = 0; i < 9; i++) exp_addrs.push_back(32'h0040_0000 + 32'(4 * i));
        for (int i = 0; i < 4; i++) exp_head(32'h0040_0000 + 32'(4 * i));
        @(negedge clk); check("s1_req_c0", i_req, 1); check("s1_val_c0", valid, 0);
        cyc(); @(negedge clk); check("s1_req_c1", i_req, 0); check("s1_val_c1", valid, 0);
        cyc(); @(negedge clk); check("s1_val_c2", valid, 1);
        repeat (7) cyc();                     // cycle 9
        ready = 1'b0;
        repeat (9) cyc();                     // cycle 18
        @(negedge clk); check("s2_full_cnt", count, 4); check("s2_full_req", i_req, 0);
        repeat (2) cyc();                     // cycle 20
        ready = 1'b1;
        exp_head(32'h0040_0010);
        cyc();                                // cycle 21
        ready = 1'b0;
        @(negedge clk); check("s2_cnt3", count, 3); check("s2_req", i_req, 1);
        repeat (3) cyc();                     // cycle 24
        @(negedge clk); check("s2_refill", count, 4); check("s2_req_off", i_req, 0);
        end_scn();

        // Redirect while waiting: the stale response for 0x100 is dropped.
        do_reset(32'h0000_0100, 2);
        ready = 1'b1;
        exp_addrs.push_back(32'h100);
        exp_addrs.push_back(32'h200);
        exp_head(32'h200);
        @(negedge clk); check("s3_req_c0", i_req, 1);
        cyc();                                // cycle 1
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk); check("s3_req_c1", i_req, 0);
        cyc();                                // cycle 2
        redirect = 1'b0;
        @(negedge clk); check("s3_drop_req", i_req, 0); check("s3_drop_cnt", count, 0);
        cyc();                                // cycle 3
        @(negedge clk); check("s3_req_c3", i_req, 1); check("s3_addr", i_addr, 32'h200);
        repeat (3) cyc();                     // cycle 6
        @(negedge clk); check("s3_val_c6", valid, 1);
        cyc();
        ready = 1'b0;
        end_scn();

        // Redirect in the same cycle as the response for 0x104, with 2 entries queued.
        do_reset(32'h0000_00FC, 1);
        exp_addrs.push_back(32'h0FC);
        exp_addrs.push_back(32'h100);
        exp_addrs.push_back(32'h104);
        exp_addrs.push_back(32'h300);
        exp_head(32'h300);
        repeat (5) cyc();                     // cycle 5
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk); check("s4_cnt2", count, 2);
        cyc();                                // cycle 6
        redirect = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("s4_flush_cnt", count, 0); check("s4_flush_val", valid, 0);
        check("s4_req", i_req, 1); check("s4_addr", i_addr, 32'h300);
        repeat (2) cyc();                     // cycle 8
        @(negedge clk); check("s4_val_c8", valid, 1);
        cyc();
        ready = 1'b0;
        end_scn();

        // Address wrap at 2^32, pointer wrap, and back-to-back pops from a full queue.
        do_reset(32'hFFFF_FFF8, 1);
        ready = 1'b1;
        exp_addrs.push_back(32'hFFFF_FFF8);
        exp_addrs.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 13; i++) exp_addrs.push_back(32'(4 * i));
        exp_head(32'hFFFF_FFF8);
        exp_head(32'hFFFF_FFFC);
        for (int i = 0; i < 12; i++) exp_head(32'(4 * i));
        repeat (21) cyc();                    // cycle 21
        ready = 1'b0;
        repeat (8) cyc();                     // cycle 29
        @(negedge clk); check("s5_full_cnt", count, 4); check("s5_full_req", i_req, 0);
        cyc();                                // cycle 30
        ready = 1'b1;
        repeat (2) cyc();                     // cycle 32
        @(negedge clk); check("s5_cnt_c32", count, 2);
        repeat (2) cyc();                     // cycle 34
        ready = 1'b0;
        @(negedge clk); check("s5_cnt_c34", count, 1);
        end_scn();

        // Misaligned redirect target.
        do_reset(32'h0000_1000, 1);
        ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h202;
        @(negedge clk); check("s6_req_c0", i_req, 0);
        cyc();                                // cycle 1
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        @(negedge clk); check("s6_mis_set", misaligned, 1); check("s6_halt_req", i_req, 0);
        cyc();                                // cycle 2
        @(negedge clk); check("s6_halt_req2", i_req, 0);
        cyc();                                // cycle 3
        redirect = 1'b1; redirect_pc = 32'h204;
        @(negedge clk); check("s6_mis_hold", misaligned, 1);
        cyc();                                // cycle 4
        redirect = 1'b0;
        exp_addrs.push_back(32'h204);
        exp_head(32'h204);
        @(negedge clk);
        check("s6_mis_clr", misaligned, 0); check("s6_req", i_req, 1); check("s6_addr", i_addr, 32'h204);
        repeat (2) cyc();                     // cycle 6
        @(negedge clk); check("s6_val", valid, 1);
        cyc();
        ready = 1'b0;
`else
        exp_addrs.push_back(32'h200);
        exp_head(32'h200);
        @(negedge clk);
        check("s6_req", i_req, 1); check("s6_addr", i_addr, 32'h200); check("s6_mis", misaligned, 0);
        repeat (2) cyc();                     // cycle 3
        @(negedge clk); check("s6_val", valid, 1);
        cyc();
        ready = 1'b0;
`endif
        end_scn();

        // Asynchronous reset in mid-operation.
        do_reset(32'h0000_0500, 1);
        exp_addrs.push_back(32'h500);
        exp_addrs.push_back(32'h504);
        exp_addrs.push_back(32'h508);
        repeat (5) cyc();                     // cycle 5
        @(negedge clk); check("s7_cnt2", count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("s7_async_cnt", count, 0);
        check("s7_async_val", valid, 0);
        check("s7_async_req", i_req, 0);
        check("s7_async_head", {pc, instr}, 0);
        check("s7_async_addr", i_addr, 32'h500);
        end_scn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
